// File: rtl/branch_resolve_unit.sv
// In-order tracker for in-flight conditional branches: records the fetch-time guess,
// checks it at execute, feeds the predictor update and raises flush on a mispredict.
module branch_resolve_unit #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_push,
  input  logic             if_guess,
  input  logic [XLEN-1:0]  if_pc,
  input  logic [XLEN-1:0]  if_target,
  output logic             if_stall,
  input  logic             ex_resolve,
  input  logic             ex_taken,
  output logic             is_branch,
  output logic             Branch_taken,
  output logic             flush,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] mispredict_cnt,
  output logic             underflow_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + CNT_W'(1);
  endfunction

  logic            guess_mem  [DEPTH];
  logic [XLEN-1:0] pc_mem     [DEPTH];
  logic [XLEN-1:0] target_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;

  // Stage p0: head lookup and resolve decision in the execute cycle
  logic            pop_p0, mis_p0, push_ok_p0, underflow_p0;
  logic [XLEN-1:0] fix_pc_p0;

  always_comb begin
    underflow_p0 = ex_resolve && (count == '0);
    pop_p0       = ex_resolve && (count != '0);
    mis_p0       = pop_p0 && (guess_mem[rd_ptr] != ex_taken);
    // A slot freed by a same-cycle pop lets a push through even when full;
    // a push alongside a mispredict is a wrong-path branch and is dropped.
    push_ok_p0   = if_push && !mis_p0 && ((count != FULL_CNT) || pop_p0);
    fix_pc_p0    = ex_taken ? target_mem[rd_ptr] : pc_mem[rd_ptr] + XLEN'(4);
  end

  assign if_stall = (count == FULL_CNT);

  always_ff @(posedge clk) begin
    if (push_ok_p0) begin
      guess_mem[wr_ptr]  <= if_guess;
      pc_mem[wr_ptr]     <= if_pc;
      target_mem[wr_ptr] <= if_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (mis_p0) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok_p0) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_p0)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok_p0, pop_p0})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Stage p1: registered predictor update and redirect
  logic             vld_p1, taken_p1, flush_p1, uf_p1;
  logic [XLEN-1:0]  redirect_p1;
  logic [CNT_W-1:0] cnt_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      taken_p1    <= 1'b0;
      flush_p1    <= 1'b0;
      redirect_p1 <= '0;
      cnt_p1      <= '0;
      uf_p1       <= 1'b0;
    end else begin
      vld_p1   <= pop_p0;
      taken_p1 <= pop_p0 ? ex_taken : 1'b0;
      flush_p1 <= mis_p0;
      if (mis_p0) begin
        redirect_p1 <= fix_pc_p0;
        cnt_p1      <= sat_inc(cnt_p1);
      end
      if (underflow_p0) uf_p1 <= 1'b1;
    end
  end

  assign is_branch      = vld_p1;
  assign Branch_taken   = taken_p1;
  assign flush          = flush_p1;
  assign redirect_pc    = redirect_p1;
  assign mispredict_cnt = cnt_p1;
  assign underflow_err  = uf_p1;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit (DEPTH=4, XLEN=32, CNT_W=4 build).
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_push, if_guess;
  logic [31:0] if_pc, if_target;
  logic        if_stall;
  logic        ex_resolve, ex_taken;
  logic        is_branch, Branch_taken, flush;
  logic [31:0] redirect_pc;
  logic [3:0]  mispredict_cnt;
  logic        underflow_err;

  always #5 clk = ~clk;

  branch_resolve_unit #(.DEPTH(4), .XLEN(32), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .if_push(if_push), .if_guess(if_guess), .if_pc(if_pc), .if_target(if_target),
    .if_stall(if_stall),
    .ex_resolve(ex_resolve), .ex_taken(ex_taken),
    .is_branch(is_branch), .Branch_taken(Branch_taken), .flush(flush),
    .redirect_pc(redirect_pc), .mispredict_cnt(mispredict_cnt),
    .underflow_err(underflow_err)
  );

  typedef struct packed {
    logic        ib;
    logic        bt;
    logic        fl;
    logic [31:0] rpc;
    logic [3:0]  cnt;
    logic        uf;
    logic        stall;
  } obs_t;

  typedef struct packed {
    logic        guess;
    logic [31:0] pc;
    logic [31:0] target;
  } ent_t;

  ent_t        mq[$];
  obs_t        sb[$];
  logic [31:0] m_rpc;
  logic [3:0]  m_cnt;
  logic        m_uf;
  int          n_vec  = 0;
  int          n_fail = 0;
  obs_t        got, exp_o;

  function automatic obs_t sample();
    obs_t o;
    o.ib = is_branch; o.bt = Branch_taken; o.fl = flush; o.rpc = redirect_pc;
    o.cnt = mispredict_cnt; o.uf = underflow_err; o.stall = if_stall;
    return o;
  endfunction

  // Drive one cycle, advance the reference model and queue the expected post-edge outputs.
  task automatic step(input logic p, input logic g, input logic [31:0] pc, input logic [31:0] tg,
                      input logic r, input logic t);
    obs_t e;
    logic pop, mis, push_ok;
    if_push = p; if_guess = g; if_pc = pc; if_target = tg;
    ex_resolve = r; ex_taken = t; rst = 1'b0;
    pop     = r && (mq.size() > 0);
    mis     = pop && (mq[0].guess != t);
    push_ok = p && !mis && ((mq.size() < 4) || pop);
    if (r && mq.size() == 0) m_uf = 1'b1;
    if (mis) begin
      m_rpc = t ? mq[0].target : mq[0].pc + 32'd4;
      if (m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
    end
    if (mis) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push_ok) mq.push_back('{g, pc, tg});
    end
    e.ib = pop; e.bt = pop ? t : 1'b0; e.fl = mis; e.rpc = m_rpc;
    e.cnt = m_cnt; e.uf = m_uf; e.stall = (mq.size() == 4);
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    obs_t e;
    rst = 1'b1; if_push = 1'b0; ex_resolve = 1'b0;
    mq.delete(); m_rpc = '0; m_cnt = '0; m_uf = 1'b0;
    e = '0;
    sb.push_back(e);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    if_guess = 0; if_pc = '0; if_target = '0; ex_taken = 0; if_push = 0; ex_resolve = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    exp_o = sb.pop_front(); got = sample(); n_vec++;
    if (got !== exp_o) begin n_fail++; $display("FAIL reset got=%h want=%h", got, exp_o); end
  endtask

  task automatic test_correct_not_taken();
    for (int i = 1; i <= 3; i++) begin
      step(1, 0, 32'h100 * i, 32'h100 * i + 32'h80, 0, 0);
      exp_o = sb.pop_front(); got = sample(); n_vec++;
      if (got !== exp_o) begin n_fail++; $display("FAIL push_nt%0d got=%h want=%h", i, got, exp_o); end
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 1, 0);
      exp_o = sb.pop_front(); got = sample(); n_vec++;
      if (got !== exp_o) begin n_fail++; $display("FAIL resolve_nt%0d got=%h want=%h", i, got, exp_o); end
    end
    step(0, 0, 0, 0, 0, 0);
    exp_o = sb.pop_front(); got = sample(); n_vec++;
    if (got !== exp_o) begin n_fail++; $display("FAIL pulse_end got=%h want=%h", got, exp_o); end
  endtask

  task automatic test_mispredict_taken();
    step(1, 0, 32'h40, 32'h80, 0, 0);
    exp_o = sb.pop_front(); got = sample(); n_vec++;
    if (got !== exp_o) begin n_fail++; $display("FAIL mp_push got=%h want=%h", got, exp_o); end
    step(0, 0, 0, 0, 1, 1);
    exp_o = sb.pop_front(); got = sample(); n_vec++;
    if (got !== exp_o || redirect_pc !== 32'h80) begin
      n_fail++; $display("FAIL mp_taken got=%h want=%h", got, exp_o);
    end
    step(0, 0, 0, 0, 0, 0);
    exp_o = sb.pop_front(); got = sample(); n_vec++;
    if (got !== exp_o) begin n_fail++; $display("FAIL mp_pulse_end got=%h want=%h", got, exp_o); end
  endtask

  task automatic test_wrap();
    step(1, 1, 32'hFFFF_FFFC, 32'h1234, 0, 0);
    exp_o = sb.pop_front(); got = sample(); n_vec++;
    if (got !== exp_o) begin n_fail++; $display("FAIL wrap_push got=%h want=%h", got, exp_o); end
    step(0, 0, 0, 0, 1, 0);
    exp_o = sb.pop_front(); got = sample(); n_vec++;
    if (got !== exp_o || redirect_pc !== 32'h0) begin
      n_fail++; $display("FAIL wrap_redirect got=%h want=%h", got, exp_o);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 32'h1000 + 32'h100 * i, 32'h1080 + 32'h100 * i, 0, 0);
      exp_o = sb.pop_front(); got = sample(); n_vec++;
      if (got !== exp_o) begin n_fail++; $display("FAIL fill%0d got=%h want=%h", i, got, exp_o); end
    end
    // push at full together with a correct resolve; the new entry must land at the tail
    step(1, 0, 32'h5000, 32'h5800, 1, 1);
    exp_o = sb.pop_front(); got = sample(); n_vec++;
    if (got !== exp_o) begin n_fail++; $display("FAIL full_push_pop got=%h want=%h", got, exp_o); end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 1, 1);
      exp_o = sb.pop_front(); got = sample(); n_vec++;
      if (got !== exp_o) begin n_fail++; $display("FAIL drain%0d got=%h want=%h", i, got, exp_o); end
    end
  endtask

  task automatic test_flush_push();
    for (int i = 0; i < 2; i++) begin
      step(1, 1, 32'h6000 + 32'h10 * i, 32'h7000, 0, 0);
      exp_o = sb.pop_front(); got = sample(); n_vec++;
      if (got !== exp_o) begin n_fail++; $display("FAIL hold%0d got=%h want=%h", i, got, exp_o); end
    end
    step(1, 1, 32'h9000, 32'h9800, 1, 1);
    exp_o = sb.pop_front(); got = sample(); n_vec++;
    if (got !== exp_o || redirect_pc !== 32'h5800) begin
      n_fail++; $display("FAIL flush_push got=%h want=%h", got, exp_o);
    end
    step(0, 0, 0, 0, 1, 0);
    exp_o = sb.pop_front(); got = sample(); n_vec++;
    if (got !== exp_o || underflow_err !== 1'b1) begin
      n_fail++; $display("FAIL underflow got=%h want=%h", got, exp_o);
    end
    // empty FIFO: resolve is underflow, simultaneous push is still written
    step(1, 1, 32'hA000, 32'hA800, 1, 1);
    exp_o = sb.pop_front(); got = sample(); n_vec++;
    if (got !== exp_o) begin n_fail++; $display("FAIL underflow_push got=%h want=%h", got, exp_o); end
    step(0, 0, 0, 0, 1, 0);
    exp_o = sb.pop_front(); got = sample(); n_vec++;
    if (got !== exp_o || redirect_pc !== 32'hA004) begin
      n_fail++; $display("FAIL nobypass_entry got=%h want=%h", got, exp_o);
    end
  endtask

  task automatic test_midreset();
    step(1, 0, 32'hB000, 32'hB800, 0, 0);
    exp_o = sb.pop_front(); got = sample(); n_vec++;
    if (got !== exp_o) begin n_fail++; $display("FAIL cnt5_push got=%h want=%h", got, exp_o); end
    step(0, 0, 0, 0, 1, 1);
    exp_o = sb.pop_front(); got = sample(); n_vec++;
    if (got !== exp_o || mispredict_cnt !== 4'd5) begin
      n_fail++; $display("FAIL cnt5 got=%h want=%h", got, exp_o);
    end
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 32'hC000 + 32'h4 * i, 32'hC800, 0, 0);
      exp_o = sb.pop_front(); got = sample(); n_vec++;
      if (got !== exp_o) begin n_fail++; $display("FAIL pre_rst%0d got=%h want=%h", i, got, exp_o); end
    end
    do_reset();
    exp_o = sb.pop_front(); got = sample(); n_vec++;
    if (got !== exp_o) begin n_fail++; $display("FAIL mid_reset got=%h want=%h", got, exp_o); end
    step(0, 0, 0, 0, 1, 0);
    exp_o = sb.pop_front(); got = sample(); n_vec++;
    if (got !== exp_o) begin n_fail++; $display("FAIL post_rst_empty got=%h want=%h", got, exp_o); end
  endtask

  task automatic test_saturation();
    do_reset();
    exp_o = sb.pop_front(); got = sample(); n_vec++;
    if (got !== exp_o) begin n_fail++; $display("FAIL sat_reset got=%h want=%h", got, exp_o); end
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 32'h2000 + 32'h8 * i, 32'h3000 + 32'h8 * i, 0, 0);
      void'(sb.pop_front());
      step(0, 0, 0, 0, 1, 1);
      exp_o = sb.pop_front(); got = sample(); n_vec++;
      if (got !== exp_o) begin n_fail++; $display("FAIL sat%0d got=%h want=%h", i, got, exp_o); end
    end
    n_vec++;
    if (mispredict_cnt !== 4'hF) begin
      n_fail++; $display("FAIL sat_final got=%0d want=15", mispredict_cnt);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      step(1, i[0], 32'hD000 + 32'h10 * i, 32'hE000 + 32'h10 * i, 0, 0);
      void'(sb.pop_front());
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 1, i[0]);
      exp_o = sb.pop_front(); got = sample(); n_vec++;
      if (got !== exp_o) begin n_fail++; $display("FAIL b2b%0d got=%h want=%h", i, got, exp_o); end
    end
  endtask

  initial begin
    test_reset();
    test_correct_not_taken();
    test_mispredict_taken();
    test_wrap();
    test_full();
    test_flush_push();
    test_midreset();
    test_saturation();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Tracks every conditional branch from fetch to execute, and lives between the IF-stage next-PC logic and the 2-bit branch predictor.
- At fetch it records the predictor's guess, the branch PC and the branch target in an in-order FIFO.
- At execute it compares the resolved outcome against the FIFO head.
- It drives the predictor's update inputs (is_branch, Branch_taken).
- On a misprediction it raises a one-cycle flush with the corrected fetch PC.

Parameters:
- DEPTH, 4, number of in-flight branch entries (power of 2, at least 2).
- XLEN, 32, PC/target width.
- CNT_W, 16, width of the misprediction counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- if_push  input  1  a conditional branch is fetched this cycle
- if_guess  input  1  predictor Guess_result for that branch (1 = taken)
- if_pc  input  XLEN  PC of the fetched branch
- if_target  input  XLEN  taken-target of the fetched branch
- if_stall  output  1  FIFO full; fetch must hold (combinational)
- ex_resolve  input  1  the oldest in-flight branch resolves this cycle
- ex_taken  input  1  actual outcome of that branch
- is_branch  output  1  registered pulse to predictor: a branch resolved last cycle
- Branch_taken  output  1  registered actual outcome, valid when is_branch=1
- flush  output  1  registered one-cycle misprediction pulse
- redirect_pc  output  XLEN  corrected fetch PC, valid when flush=1
- mispredict_cnt  output  CNT_W  saturating count of mispredictions
- underflow_err  output  1  sticky: ex_resolve arrived while the FIFO was empty

Behaviour:
Reset (synchronous, rst=1 at a rising edge):
- FIFO empty; read and write pointers = 0.
- is_branch=0, Branch_taken=0, flush=0, redirect_pc=0, mispredict_cnt=0, underflow_err=0.
- Reset mid-operation discards all in-flight entries. No flush is generated.

FIFO:
- Each entry is {guess, pc, target}.
- Occupancy count ranges 0..DEPTH, with wrap-around pointers of log2(DEPTH) bits.
- if_stall = (count == DEPTH).
- A push while full is ignored. The entry is not written and the count is unchanged.

Resolve:
- When ex_resolve=1 and count>0, the head is popped and compared.
- Next cycle: is_branch=1 and Branch_taken=ex_taken. Latency to the predictor is exactly 1 cycle.
- If head.guess != ex_taken, then next cycle:
  - flush=1;
  - redirect_pc = ex_taken ? head.target : head.pc + 4 (modulo 2^XLEN);
  - mispredict_cnt increments and saturates at all-ones.
- On a misprediction, every younger entry is on the wrong path. The FIFO is cleared in the same edge as the pop, so count becomes 0.
- On a correct prediction there is no flush, and redirect_pc holds its previous value.
- ex_resolve=1 with count=0: no pop, is_branch=0 next cycle, underflow_err set to 1 until reset.

Simultaneous events at the same edge:
- Push + correct resolve: both happen; count is unchanged (a push is allowed even at full, since a slot frees).
- Push + mispredict: the push is dropped (wrong-path branch); count becomes 0.
- Push with count=0 and resolve: no bypass. The resolve is treated as underflow, and the push is written.

Pulse widths:
- is_branch and flush are high for exactly one cycle per resolve.
- Back-to-back resolves give back-to-back pulses.

Test Plan:
1. Reset, then push 3 branches with guess=0 (pc 0x100, 0x200, 0x300; target 0x180, 0x280, 0x380). Resolve all with ex_taken=0 → three is_branch pulses with Branch_taken=0, flush never high, mispredict_cnt=0.
2. Push a branch {guess=0, pc=0x40, target=0x80}, resolve ex_taken=1 → next cycle flush=1, redirect_pc=0x80, Branch_taken=1, mispredict_cnt=1.
3. Push {guess=1, pc=0xFFFFFFFC}, resolve ex_taken=0 → flush=1, redirect_pc=0x00000000 (wrap-around).
4. Push 4 entries (DEPTH=4) → if_stall=1; a 5th push is ignored. Then push and correct-resolve in the same cycle → count stays 4, and the new entry is at the tail.
5. With 3 entries held, mispredict the head while pushing → FIFO empty afterwards, if_stall=0. A further ex_resolve sets underflow_err=1.
6. Assert rst with 2 entries held and mispredict_cnt=5 → all outputs 0 next cycle and the FIFO empty. Force mispredict_cnt to saturation (CNT_W=4 build: 15 mispredicts, then one more) → the count stays at 15.
